xcom_qctrl_seq: RTL and testbench

- Parametrised successor of the tProc quick-control decoder. Queues quick-control and quick-sync requests in a small FIFO and executes them one at a time.
- Each request is decoded to a one-hot control pulse of configurable length. Sync requests first wait for a sync-pulse rising edge, bounded by a timeout.
- Sits between the xcom receive path and tProc control inputs. Single clock domain; CDC to other domains is done outside this block.

---
 rtl/xcom_qctrl_seq.sv | 199 +++++++++++++++++++
 tb/tb_xcom_qctrl_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xcom_qctrl_seq.sv
// Request queue: stores {is_sync, code} entries until the sequencer pops them.
// Latency: a push at edge E is visible at the head after E; a pop takes effect at the next edge.
// Backpressure: wr_rdy drops when full unless a pop happens in the same cycle; clr empties the queue.
module xcom_qctrl_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     t_clk_i,
    input  logic                     t_rst_ni,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign rd_vld = (level != '0);
    assign rd_en  = rd_vld & rd_rdy;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign wr_rdy = (level != (AW+1)'(DEPTH)) | rd_en;
    assign wr_en  = wr_vld & wr_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge t_clk_i) begin
        if (wr_en && !clr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Quick-control sequencer: queues ctrl/sync requests and plays each as a one-hot pulse of PULSE_LEN cycles.
// Latency: request sampled at E -> pulse from E+1 when idle; sync pulse rises 3 edges after pulse_sync_i.
// Backpressure: none upstream; requests hitting a full queue (or losing a ctrl/sync collision) are dropped with drop_o.
module xcom_qctrl_seq #(
    parameter int CW         = 3,
    parameter int PULSE_LEN  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_TO    = 1024,
    parameter int SYNC_CMD   = 6
) (
    input  logic                          t_clk_i,
    input  logic                          t_rst_ni,
    input  logic                          pulse_sync_i,
    input  logic                          qctrl_req_i,
    input  logic [CW-1:0]                 qctrl_dt_i,
    input  logic                          qsync_req_i,
    input  logic                          flush_i,
    output logic [2**CW-1:0]              ctrl_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          drop_o,
    output logic                          sync_to_o
);
    localparam int             CNT_W     = $clog2(PULSE_LEN + SYNC_TO + 1) + 1;
    localparam logic [CW-1:0]  SYNC_CODE = CW'(SYNC_CMD);
    localparam logic [1:0]     ST_IDLE   = 2'd0;
    localparam logic [1:0]     ST_WSYNC  = 2'd1;
    localparam logic [1:0]     ST_EXEC   = 2'd2;

    typedef struct packed {
        logic          is_sync;
        logic [CW-1:0] code;
    } req_t;

    logic             sync_q1, sync_q2, sync_q3;
    logic             sync_edge;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    cmd_code;
    req_t             wr_dat;
    req_t             rd_dat;
    logic             req_any;
    logic             fifo_wr_vld, fifo_wr_rdy;
    logic             fifo_rd_rdy, fifo_rd_vld;
    logic             drop_nxt;

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= pulse_sync_i;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end
    assign sync_edge = sync_q2 & ~sync_q3;

    // Sync wins a same-cycle collision; the ctrl request is the one discarded.
    always_comb begin
        wr_dat.is_sync = qsync_req_i;
        wr_dat.code    = qsync_req_i ? SYNC_CODE : qctrl_dt_i;
    end

    assign req_any     = qsync_req_i | qctrl_req_i;
    assign fifo_wr_vld = req_any & ~flush_i;
    assign fifo_rd_rdy = (state == ST_IDLE) & ~flush_i;
    assign drop_nxt    = ~flush_i & ((qsync_req_i & qctrl_req_i) | (req_any & ~fifo_wr_rdy));

    xcom_qctrl_fifo #(
        .W     (CW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .t_clk_i  (t_clk_i),
        .t_rst_ni (t_rst_ni),
        .clr      (flush_i),
        .wr_vld   (fifo_wr_vld),
        .wr_dat   (wr_dat),
        .wr_rdy   (fifo_wr_rdy),
        .rd_rdy   (fifo_rd_rdy),
        .rd_vld   (fifo_rd_vld),
        .rd_dat   (rd_dat),
        .level    (level_o)
    );

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd_code  <= '0;
            drop_o    <= 1'b0;
            sync_to_o <= 1'b0;
        end else begin
            drop_o    <= drop_nxt;
            sync_to_o <= 1'b0;
            if (flush_i) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fifo_rd_vld) begin
                            cmd_code <= rd_dat.code;
                            state    <= rd_dat.is_sync ? ST_WSYNC : ST_EXEC;
                            cnt      <= '0;
                        end
                    end
                    ST_WSYNC: begin
                        if (sync_edge) begin
                            state <= ST_EXEC;
                            cnt   <= '0;
                        end else if (SYNC_TO != 0 && cnt == CNT_W'(SYNC_TO - 1)) begin
                            state     <= ST_IDLE;
                            cnt       <= '0;
                            sync_to_o <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_EXEC: begin
                        if (cnt == CNT_W'(PULSE_LEN - 1)) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Code 0 is a NOP: it occupies the sequencer but drives no line.
    always_comb begin
        ctrl_o = '0;
        if (state == ST_EXEC && cmd_code != '0) ctrl_o[cmd_code] = 1'b1;
    end

    assign busy_o = fifo_rd_vld | (state != ST_IDLE);
endmodule

// File: tb/tb_xcom_qctrl_seq.sv
// Bench for xcom_qctrl_seq: queue/countdown reference model checked every cycle, plus directed literal checks.
module tb_xcom_qctrl_seq;
    localparam int CW = 3, PL = 8, DEPTH = 4, STO = 16, SCMD = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse_sync, qctrl_req, qsync_req, flush;
    logic [2:0] dt;
    logic [7:0] ctrl;
    logic       busy, drop, sync_to;
    logic [2:0] level;

    int n_cmp, n_err;
    bit chk_en;

    always #5 clk = ~clk;

    xcom_qctrl_seq #(
        .CW(CW), .PULSE_LEN(PL), .FIFO_DEPTH(DEPTH), .SYNC_TO(STO), .SYNC_CMD(SCMD)
    ) dut (
        .t_clk_i      (clk),
        .t_rst_ni     (rst_n),
        .pulse_sync_i (pulse_sync),
        .qctrl_req_i  (qctrl_req),
        .qctrl_dt_i   (dt),
        .qsync_req_i  (qsync_req),
        .flush_i      (flush),
        .ctrl_o       (ctrl),
        .busy_o       (busy),
        .level_o      (level),
        .drop_o       (drop),
        .sync_to_o    (sync_to)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending requests, a countdown of remaining pulse cycles,
    // a waiting flag with its age, and the three-sample history of the sync input.
    typedef struct packed {
        bit       is_sync;
        bit [2:0] code;
    } m_ent_t;

    m_ent_t   m_q[$];
    m_ent_t   m_head;
    int       m_left, m_age, m_code;
    bit       m_wait, m_drop, m_sto, m_sedge;
    bit [2:0] m_sh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_left = 0; m_age = 0; m_code = 0;
            m_wait = 0; m_drop = 0; m_sto = 0; m_sh = 3'b000;
        end else begin
            m_sedge = m_sh[1] & ~m_sh[2];
            m_sh    = {m_sh[1:0], pulse_sync};
            m_drop  = 0;
            m_sto   = 0;
            if (flush) begin
                m_q.delete();
                m_left = 0;
                m_wait = 0;
            end else begin
                if (m_left > 0) begin
                    m_left--;
                end else if (m_wait) begin
                    if (m_sedge) begin
                        m_wait = 0; m_left = PL; m_code = SCMD;
                    end else if (STO != 0 && m_age == STO - 1) begin
                        m_wait = 0; m_sto = 1;
                    end else begin
                        m_age++;
                    end
                end else if (m_q.size() > 0) begin
                    m_head = m_q.pop_front();
                    m_code = int'(m_head.code);
                    if (m_head.is_sync) begin
                        m_wait = 1; m_age = 0;
                    end else begin
                        m_left = PL;
                    end
                end
                if (qsync_req || qctrl_req) begin
                    if (m_q.size() < DEPTH)
                        m_q.push_back(qsync_req ? m_ent_t'({1'b1, 3'(SCMD)}) : m_ent_t'({1'b0, dt}));
                    else
                        m_drop = 1;
                    if (qsync_req && qctrl_req) m_drop = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ctrl", 32'(ctrl), (m_left > 0 && m_code != 0) ? (32'd1 << m_code) : 32'd0);
            check("cyc_busy", 32'(busy), 32'((m_q.size() > 0) || (m_left > 0) || m_wait));
            check("cyc_level", 32'(level), 32'(m_q.size()));
            check("cyc_drop", 32'(drop), 32'(m_drop));
            check("cyc_sync_to", 32'(sync_to), 32'(m_sto));
        end
    end

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy === 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("idle_reached", 32'(i < budget), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; chk_en = 0;
        rst_n = 1'b0; pulse_sync = 1'b0; qctrl_req = 1'b0; qsync_req = 1'b0; flush = 1'b0; dt = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_sync_to", 32'(sync_to), 32'd0);
        rst_n = 1'b1; chk_en = 1;

        // Single request, code 3.
        @(negedge clk); qctrl_req = 1'b1; dt = 3'd3;
        @(negedge clk); qctrl_req = 1'b0;
        @(negedge clk); check("t1_ctrl_first", 32'(ctrl), 32'h08);
        repeat (7) @(negedge clk);
        check("t1_ctrl_last", 32'(ctrl), 32'h08);
        @(negedge clk);
        check("t1_ctrl_end", 32'(ctrl), 32'h00);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Back-to-back codes 4, 5, 7.
        @(negedge clk); qctrl_req = 1'b1; dt = 3'd4;
        @(negedge clk); dt = 3'd5;
        @(negedge clk); check("t2_ctrl_first", 32'(ctrl), 32'h10); dt = 3'd7;
        @(negedge clk); qctrl_req = 1'b0; check("t2_level_peak", 32'(level), 32'd2);
        repeat (7) @(negedge clk);
        check("t2_gap", 32'(ctrl), 32'h00);
        @(negedge clk); check("t2_ctrl_second", 32'(ctrl), 32'h20);
        wait_idle(100);

        // Overflow: six requests while the first executes.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("t3_level_full", 32'(level), 32'd4);
                check("t3_no_drop_yet", 32'(drop), 32'd0);
            end
            qctrl_req = 1'b1; dt = 3'(i + 1);
        end
        @(negedge clk); qctrl_req = 1'b0;
        check("t3_drop", 32'(drop), 32'd1);
        check("t3_level_kept", 32'(level), 32'd4);
        wait_idle(200);

        // Simultaneous sync+ctrl, then sync timeout with no pulse.
        @(negedge clk); qsync_req = 1'b1; qctrl_req = 1'b1; dt = 3'd5;
        @(negedge clk); qsync_req = 1'b0; qctrl_req = 1'b0;
        check("t4_drop", 32'(drop), 32'd1);
        check("t4_level", 32'(level), 32'd1);
        repeat (16) @(negedge clk);
        check("t4_no_to_yet", 32'(sync_to), 32'd0);
        @(negedge clk);
        check("t4_sync_to", 32'(sync_to), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // Sync request satisfied by a pulse.
        @(negedge clk); qsync_req = 1'b1;
        @(negedge clk); qsync_req = 1'b0;
        repeat (9) @(negedge clk);
        #1 pulse_sync = 1'b1;
        @(negedge clk);
        @(negedge clk); check("t5_before", 32'(ctrl), 32'h00);
        @(negedge clk); check("t5_rise", 32'(ctrl), 32'h40);
        repeat (7) @(negedge clk);
        check("t5_hold", 32'(ctrl), 32'h40);
        @(negedge clk); check("t5_end", 32'(ctrl), 32'h00); pulse_sync = 1'b0;
        wait_idle(100);

        // NOP followed by code 2.
        @(negedge clk); qctrl_req = 1'b1; dt = 3'd0;
        @(negedge clk); dt = 3'd2;
        @(negedge clk); qctrl_req = 1'b0;
        check("t6_nop_ctrl", 32'(ctrl), 32'h00);
        check("t6_nop_busy", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        check("t6_code2", 32'(ctrl), 32'h04);
        wait_idle(100);

        // Flush mid-execution with three queued.
        @(negedge clk); qctrl_req = 1'b1; dt = 3'd1;
        @(negedge clk); dt = 3'd2;
        @(negedge clk); dt = 3'd3;
        @(negedge clk); dt = 3'd4;
        @(negedge clk); qctrl_req = 1'b0;
        check("t7_level", 32'(level), 32'd3);
        check("t7_ctrl", 32'(ctrl), 32'h02);
        @(negedge clk); flush = 1'b1; qctrl_req = 1'b1; dt = 3'd7;
        @(negedge clk); flush = 1'b0; qctrl_req = 1'b0;
        check("t7_flush_ctrl", 32'(ctrl), 32'h00);
        check("t7_flush_level", 32'(level), 32'd0);
        check("t7_flush_busy", 32'(busy), 32'd0);
        check("t7_flush_nodrop", 32'(drop), 32'd0);

        // Async reset while waiting for sync with requests queued.
        @(negedge clk); qsync_req = 1'b1;
        @(negedge clk); qsync_req = 1'b0; qctrl_req = 1'b1; dt = 3'd3;
        @(negedge clk); dt = 3'd5;
        @(negedge clk); qctrl_req = 1'b0;
        check("t8_level_pre", 32'(level), 32'd2);
        check("t8_busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_ctrl", 32'(ctrl), 32'd0);
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_level", 32'(level), 32'd0);
        check("t8_rst_drop", 32'(drop), 32'd0);
        check("t8_rst_sync_to", 32'(sync_to), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            qctrl_req = ($urandom_range(99) < 30);
            dt        = 3'($urandom_range(7));
            qsync_req = ($urandom_range(99) < 6);
            flush     = ($urandom_range(199) < 2);
            if ($urandom_range(99) < 8) pulse_sync = ~pulse_sync;
        end
        @(negedge clk); qctrl_req = 1'b0; qsync_req = 1'b0; flush = 1'b0;
        wait_idle(300);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
